nand_way_scheduler: RTL

//  Schedules flash page requests (mapping pointers) onto NAND ways. Queues up to QUEUE_DEPTH requests.

---
 rtl/nand_way_scheduler.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/nand_way_scheduler.sv
// nand_way_scheduler: age-ordered request queue that issues the oldest request whose NAND way is idle.
// Latency: a request is written to the queue at its accept edge and loaded into the command register on the next edge.
// Backpressure: req_ready drops when the queue is full; a presented command holds until cmd_ready. Optional feature macro: WAY_TIMEOUT_EN.
module nand_way_scheduler #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int NUM_WAYS       = 2,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [C_DATA_WIDTH-1:0] i_req_ptr,
  input  logic [TAG_WIDTH-1:0]    i_req_tag,
  output logic                    o_cmd_valid,
  input  logic                    i_cmd_ready,
  output logic [3:0]              o_cmd_way,
  output logic [C_DATA_WIDTH-1:0] o_cmd_row,
  output logic [TAG_WIDTH-1:0]    o_cmd_tag,
  input  logic                    i_done_valid,
  input  logic [3:0]              i_done_way,
  output logic [NUM_WAYS-1:0]     o_way_busy,
  output logic [3:0]              o_q_count,
  output logic                    o_err_done,
  output logic [NUM_WAYS-1:0]     o_timeout_way
);

  localparam int WAY_BITS = $clog2(NUM_WAYS);
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  // Queue storage: slot 0 is the oldest, slots [0, r_count) are occupied.
  logic [3:0]              r_q_way [QUEUE_DEPTH];
  logic [C_DATA_WIDTH-1:0] r_q_row [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]    r_q_tag [QUEUE_DEPTH];
  logic [3:0]              r_count;

  logic [0:0]              r_state;
  logic [3:0]              r_cmd_way;
  logic [C_DATA_WIDTH-1:0] r_cmd_row;
  logic [TAG_WIDTH-1:0]    r_cmd_tag;
  logic [NUM_WAYS-1:0]     r_busy;
  logic                    r_err;

  logic [3:0]              w_enq_way;
  logic [11:0]             w_blk;
  logic [15:0]             w_page;
  logic [C_DATA_WIDTH-1:0] w_enq_row;
  logic                    w_enq;

  logic                    w_found;
  logic [3:0]              w_sel_idx;
  logic [3:0]              w_sel_way;
  logic [C_DATA_WIDTH-1:0] w_sel_row;
  logic [TAG_WIDTH-1:0]    w_sel_tag;
  logic                    w_load;

  logic [3:0]              w_nq_way [QUEUE_DEPTH];
  logic [C_DATA_WIDTH-1:0] w_nq_row [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]    w_nq_tag [QUEUE_DEPTH];
  logic [3:0]              w_cnt_after;
  logic [3:0]              w_cnt_next;

  logic [NUM_WAYS-1:0]     w_busy_nxt;
  logic                    w_err_nxt;
  logic [NUM_WAYS-1:0]     w_to_nxt;

  // Pointer bits between the way index and the block field carry no meaning here.
  logic                    w_unused_bits;
  assign w_unused_bits = ^{i_req_ptr[3:0], (TIMEOUT_CYCLES > 0)};

  // Channel/way/block/page decode of the incoming pointer.
  always_comb begin
    w_enq_way = '0;
    w_enq_way[WAY_BITS-1:0] = i_req_ptr[WAY_BITS-1:0];
  end

  assign w_blk     = i_req_ptr[15:4];
  assign w_page    = i_req_ptr[31:16];
  assign w_enq_row = ({20'd0, w_blk} << 8) + {16'd0, w_page};

  // Ready is based purely on registered occupancy, so a full queue never accepts.
  assign o_req_ready = (r_count < 4'(QUEUE_DEPTH));
  assign w_enq       = i_req_valid && o_req_ready;

  // Pick the oldest occupied slot whose way is idle (pre-edge busy flags).
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_sel_way = '0;
    w_sel_row = '0;
    w_sel_tag = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (!w_found && (4'(i) < r_count) && !r_busy[r_q_way[i][WAY_BITS-1:0]]) begin
        w_found   = 1'b1;
        w_sel_idx = 4'(i);
        w_sel_way = r_q_way[i];
        w_sel_row = r_q_row[i];
        w_sel_tag = r_q_tag[i];
      end
    end
  end

  assign w_load = (r_state == ST_IDLE) && w_found;

  // Next queue image: compact over the removed slot, then append behind the survivors.
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      w_nq_way[i] = r_q_way[i];
      w_nq_row[i] = r_q_row[i];
      w_nq_tag[i] = r_q_tag[i];
    end
    w_cnt_after = r_count - {3'b000, w_load};
    if (w_load) begin
      for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
        if (4'(i) >= w_sel_idx) begin
          w_nq_way[i] = r_q_way[i+1];
          w_nq_row[i] = r_q_row[i+1];
          w_nq_tag[i] = r_q_tag[i+1];
        end
      end
    end
    if (w_enq) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (4'(i) == w_cnt_after) begin
          w_nq_way[i] = w_enq_way;
          w_nq_row[i] = w_enq_row;
          w_nq_tag[i] = i_req_tag;
        end
      end
    end
    w_cnt_next = w_cnt_after + {3'b000, w_enq};
  end

  // Queue state update.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_way[i] <= '0;
        r_q_row[i] <= '0;
        r_q_tag[i] <= '0;
      end
    end else begin
      r_count <= w_cnt_next;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_way[i] <= w_nq_way[i];
        r_q_row[i] <= w_nq_row[i];
        r_q_tag[i] <= w_nq_tag[i];
      end
    end
  end

`ifdef WAY_TIMEOUT_EN
  localparam int CT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CT_W-1:0]     r_to_cnt [NUM_WAYS];
  logic [NUM_WAYS-1:0] r_timeout;
`endif

  // Busy flag next state: done clears, watchdog expiry clears, a load sets.
  always_comb begin
    w_busy_nxt = r_busy;
    w_err_nxt  = 1'b0;
    w_to_nxt   = '0;
    if (i_done_valid) begin
      if (({1'b0, i_done_way} < 5'(NUM_WAYS)) && r_busy[i_done_way[WAY_BITS-1:0]]) begin
        w_busy_nxt[i_done_way[WAY_BITS-1:0]] = 1'b0;
      end else begin
        w_err_nxt = 1'b1;
      end
    end
`ifdef WAY_TIMEOUT_EN
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_busy[w] && w_busy_nxt[w] && (r_to_cnt[w] == CT_W'(TIMEOUT_CYCLES - 1))) begin
        w_busy_nxt[w] = 1'b0;
        w_to_nxt[w]   = 1'b1;
      end
    end
`endif
    if (w_load) begin
      w_busy_nxt[w_sel_way[WAY_BITS-1:0]] = 1'b1;
    end
  end

  // Busy flags and the completion-error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_err  <= w_err_nxt;
    end
  end

`ifdef WAY_TIMEOUT_EN
  // Watchdog: count consecutive busy cycles per way; restart whenever the way goes idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timeout <= '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        r_to_cnt[w] <= '0;
      end
    end else begin
      r_timeout <= w_to_nxt;
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (r_busy[w] && w_busy_nxt[w]) begin
          r_to_cnt[w] <= r_to_cnt[w] + 1'b1;
        end else begin
          r_to_cnt[w] <= '0;
        end
      end
    end
  end

  assign o_timeout_way = r_timeout;
`else
  assign o_timeout_way = '0;
`endif

  // Output FSM: load from the queue when idle, then hold the command until accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cmd_way <= '0;
      r_cmd_row <= '0;
      r_cmd_tag <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state   <= ST_PRESENT;
            r_cmd_way <= w_sel_way;
            r_cmd_row <= w_sel_row;
            r_cmd_tag <= w_sel_tag;
          end
        end
        ST_PRESENT: begin
          if (i_cmd_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_valid = (r_state == ST_PRESENT);
  assign o_cmd_way   = r_cmd_way;
  assign o_cmd_row   = r_cmd_row;
  assign o_cmd_tag   = r_cmd_tag;
  assign o_way_busy  = r_busy;
  assign o_q_count   = r_count;
  assign o_err_done  = r_err;

endmodule
